pipe_elastic_stage: RTL and testbench
=====================================

# pipe_elastic_stage

Parametrised elastic pipeline register for the pipelined ARM core. It generalises the fixed MEM/WB latch into a DEPTH-slot valid/ready chain carrying an arbitrary DATA_W payload, with stall back-pressure, synchronous flush, and an occupancy count. It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), and the packed control and data fields of each stage boundary form its payload.

## Interface
- DATA_W, 72: payload width in bits, ≥1.
- DEPTH, 1: number of register slots, 1..4.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush_i  in  1  synchronous kill of every in-flight entry.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  slot DEPTH-1 holds a valid payload.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  payload of slot DEPTH-1.
- occupancy  out  $clog2(DEPTH+2)  count of valid entries, including the skid entry when present.

## Operation
- Slots 0..DEPTH-1 each hold v[k] and d[k]. Slot 0 is fed from the input and slot DEPTH-1 drives the outputs.
- A transfer occurs on an edge where valid and ready are both high, at either port.
- adv[DEPTH-1] = out_ready | !v[DEPTH-1]. For k<DEPTH-1, adv[k] = adv[k+1] | !v[k+1].
- Slot k loads from slot k-1, or from the input for k=0, when adv[k] is high. v[k] takes the source valid and d[k] loads only when the source valid is high, so bubbles do not toggle data.
- Without skid: in_ready = adv[0] & !flush_i. This path is combinational from out_ready.
- Flush: on an edge with flush_i=1, every v[k] clears, along with the skid valid. An input presented in that cycle is dropped: in_ready=0. out_valid may still be high during the flush cycle, but the bench must not count a transfer there. A producer holding in_valid across the flush retransmits on the next cycle.
- Reset: every v[k], d[k], skid register, and occupancy goes to 0. Therefore in_ready=1 (unless flush_i), out_valid=0, out_data=0 and occupancy=0.
- Occupancy is registered. It gets +1 on an input transfer, -1 on an output transfer, and no change when both occur together. A flush forces it to 0 regardless of simultaneous transfers.

## Timing
- Latency: a payload accepted at edge N appears on out_data after edge N+DEPTH-1, provided the chain never stalls. For DEPTH=1 it is visible immediately after the accepting edge.
- Throughput: one transfer per cycle with sustained valid/ready.
- Full chain with out_ready=0: in_ready=0. With out_ready=1 the same cycle, in_ready=1 and the full chain shifts (pass-through).
- A payload never changes while out_valid=1 and out_ready=0.
- Reset asserted mid-stream discards all entries immediately and asynchronously. No transfer is reported on the deasserting edge.

## Configuration
- PIPE_SKID_EN defined: adds one skid register (sv, sd) ahead of slot 0.
  - in_ready = !sv & !flush_i, taken from a flop, so there is no combinational path from out_ready to in_ready.
  - If an input transfers while adv[0]=0, the payload goes into the skid register.
  - When sv=1, slot 0 loads from the skid register with priority over the input.
  - Capacity becomes DEPTH+1 and latency is unchanged when the chain is not stalled.
- PIPE_SKID_EN undefined: no skid register, with the combinational in_ready described above.

## Structure
- Shared package core_pipe_pkg holds:
  - the typedefs for each stage payload struct (e.g. memwb_payload_t with read_data[31:0], alu_out[31:0], wa3[3:0], mem_to_reg, reg_write, pc_src), with its width constant MEMWB_W=72;
  - localparam MAX_PIPE_DEPTH=4.
- Sub-module pipe_slot is one valid+data flop with load enable and synchronous clear. It is instantiated DEPTH times through a generate loop.

## Test plan
- Reset then idle, DEPTH=2: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Stream 0x11, 0x22, 0x33 with out_ready=1, DEPTH=2: outputs appear in order, each one edge after the next slot's load, and occupancy is steady at 2.
- DEPTH=2, out_ready=0, continuous input: in_ready drops after 2 accepts (3 with PIPE_SKID_EN), and out_data holds 0x11 stable.
- Full chain, out_ready=1 and in_valid=1 together: simultaneous transfer, occupancy unchanged, no bubble.
- flush_i pulse with 2 entries and in_valid=1: next cycle occupancy=0, out_valid=0, and the flush-cycle input is absent from the output.
- Reset asserted mid-stream between edges: outputs are 0 immediately, and the first post-reset input is 0xAA, which emerges with no stale entries.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared stage-boundary payload types and pipeline limits
// Holds the packed payload struct for the MEM/WB boundary, its width constant,
// and the maximum depth any elastic pipeline stage may be configured with.
package core_pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [3:0]  wa3;
        logic        mem_to_reg;
        logic        reg_write;
        logic        pc_src;
        logic        spare;
    } memwb_payload_t;

    // The spare bit rounds the MEM/WB boundary out to its 72-bit width.
    localparam int MEMWB_W = $bits(memwb_payload_t);

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data register slot of an elastic pipeline
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clr_i       - synchronous clear of the valid bit (flush)
//   ld_i        - load enable; valid follows v_i, data loads only when v_i=1
//   v_i, d_i    - source valid and payload
//   v_o, d_o    - registered valid and payload
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);

    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    // Data only moves when a real payload arrives, so bubbles leave it untouched.
    always_comb begin
        v_d = clr_i ? 1'b0 : ld_i ? v_i : v_q;
        d_d = (ld_i && v_i && !clr_i) ? d_i : d_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: DEPTH-slot valid/ready elastic pipeline register
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   flush_i              - synchronous kill of all in-flight entries
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload (slot DEPTH-1)
//   occupancy            - registered count of valid entries (skid included)
// Optional build macro PIPE_SKID_EN adds a skid register ahead of slot 0 so that
// in_ready comes from a flop instead of combinationally from out_ready.
module pipe_elastic_stage
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int DEPTH  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+2);

    if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("pipe_elastic_stage: DEPTH out of range");
    end

    logic [DEPTH-1:0]  slot_v;
    logic [DATA_W-1:0] slot_d [DEPTH];
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_d [DEPTH];
    logic [DEPTH-1:0]  adv;
    logic              acc;
    logic              head_v;
    logic [DATA_W-1:0] head_d;
    logic              in_xfer, out_xfer;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // A slot may advance when the slot after it advances or is empty.
    always_comb begin
        adv = '0;
        acc = out_ready | ~slot_v[DEPTH-1];
        adv[DEPTH-1] = acc;
        for (int k = DEPTH-2; k >= 0; k--) begin
            acc = acc | ~slot_v[k+1];
            adv[k] = acc;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign src_v[k] = head_v;
            assign src_d[k] = head_d;
        end else begin : g_chain
            assign src_v[k] = slot_v[k-1];
            assign src_d[k] = slot_d[k-1];
        end
        pipe_slot #(.W(DATA_W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .clr_i (flush_i),
            .ld_i  (adv[k]),
            .v_i   (src_v[k]),
            .d_i   (src_d[k]),
            .v_o   (slot_v[k]),
            .d_o   (slot_d[k])
        );
    end

`ifdef PIPE_SKID_EN
    logic              sv_q, sv_d;
    logic [DATA_W-1:0] sd_q, sd_d;

    // A held skid entry feeds slot 0 ahead of any new input.
    assign in_ready = ~sv_q & ~flush_i;
    assign head_v   = sv_q | in_valid;
    assign head_d   = sv_q ? sd_q : in_data;

    // Capture into the skid only when an input is accepted but slot 0 is stalled.
    always_comb begin
        sv_d = flush_i ? 1'b0 : sv_q ? ~adv[0] : (in_valid & ~adv[0]);
        sd_d = (~sv_q & in_valid & ~adv[0]) ? in_data : sd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv_q <= 1'b0;
            sd_q <= '0;
        end else begin
            sv_q <= sv_d;
            sd_q <= sd_d;
        end
    end
`else
    assign in_ready = adv[0] & ~flush_i;
    assign head_v   = in_valid;
    assign head_d   = in_data;
`endif

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = slot_v[DEPTH-1] & out_ready;

    always_comb begin
        occ_d = flush_i ? '0 : occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign out_valid = slot_v[DEPTH-1];
    assign out_data  = slot_d[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// tb_pipe_elastic_stage: scoreboard bench for the elastic pipeline stage
module tb_pipe_elastic_stage;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
`ifdef PIPE_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int CAP = DEPTH + SKID;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush_i = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            cnt = 0;
    bit            hold = 0;
    logic [DW-1:0] hold_d = '0;

    always #5 clk = ~clk;

    pipe_elastic_stage #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; acceptance is judged at the falling edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f, output bit a);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush_i   = f;
        @(negedge clk);
        a = in_valid && in_ready;
        if (a) exp_q.push_back(d);
    endtask

    task automatic idle(input int n, input logic r);
        bit a;
        repeat (n) drive(1'b0, '0, r, 1'b0, a);
    endtask

    // Monitor: reference FIFO of accepted payloads plus an entry count.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            cnt  = 0;
            hold = 0;
        end else begin
            chk("occupancy", 32'(occupancy), 32'(cnt));
            if (hold) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && out_ready && !flush_i) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (flush_i) begin
                cnt = 0;
                exp_q.delete();
            end else begin
                cnt = cnt + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
            hold   = out_valid && !out_ready && !flush_i;
            hold_d = out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            a, found;
        int            n;
        logic [DW-1:0] val;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        drive(1'b1, 8'h11, 1'b1, 1'b0, a);
        drive(1'b1, 8'h22, 1'b1, 1'b0, a);
        drive(1'b1, 8'h33, 1'b1, 1'b0, a);
        drive(1'b0, 8'h00, 1'b1, 1'b0, a);
        chk("stream_data", 32'(out_data), 32'h22);
        chk("stream_occ", 32'(occupancy), 32'd2);
        idle(4, 1'b1);

        val = 8'h11;
        n = 0;
        repeat (6) begin
            drive(1'b1, val, 1'b0, 1'b0, a);
            if (a) begin
                n++;
                val++;
            end
        end
        chk("stall_accepts", 32'(n), 32'(CAP));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_data", 32'(out_data), 32'h11);

        drive(1'b1, val, 1'b1, 1'b0, a);
        chk("pass_in_ready", 32'(a), 32'(1 - SKID));
        if (a) val++;
        drive(1'b1, val, 1'b1, 1'b0, a);
        chk("pass_occ", 32'(occupancy), 32'(DEPTH));
        chk("pass_out_valid", 32'(out_valid), 32'd1);
        idle(6, 1'b1);

        drive(1'b1, 8'h41, 1'b0, 1'b0, a);
        drive(1'b1, 8'h42, 1'b0, 1'b0, a);
        drive(1'b1, 8'h43, 1'b0, 1'b1, a);
        chk("flush_pre_occ", 32'(occupancy), 32'd2);
        chk("flush_in_ready", 32'(a), 32'd0);
        drive(1'b1, 8'h43, 1'b1, 1'b0, a);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_retx", 32'(a), 32'd1);
        idle(4, 1'b1);

        drive(1'b1, 8'h51, 1'b1, 1'b0, a);
        drive(1'b1, 8'h52, 1'b0, 1'b0, a);
        @(posedge clk);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        drive(1'b1, 8'hAA, 1'b1, 1'b0, a);
        chk("aa_accept", 32'(a), 32'd1);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, a);
            if (out_valid) begin
                found = 1;
                chk("aa_first_out", 32'(out_data), 32'hAA);
            end
        end
        if (!found) chk("aa_timeout", 32'd0, 32'd1);
        idle(3, 1'b1);

        repeat (400) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 29) == 0), a);
        end
        idle(10, 1'b1);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
